fifo_out_buf: RTL and testbench
===============================

// Module: fifo_out_buf
// PURPOSE
//  Parametrised synchronous output buffer between the divider datapath and the
//  result consumer. Valid/ready on both sides, first-word fall-through read,
//  any DEPTH >= 2 (power of two not required), occupancy count, almost-full and
//  almost-empty flags, synchronous flush and an overflow-attempt pulse.
// PARAMETERS
//  DATA_WIDTH  65  width of one entry (quotient+remainder+flag)
//  DEPTH       4   number of entries, >= 2, any integer
//  AF_LEVEL    3   almost_full_o asserted when count_o >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    1   almost_empty_o asserted when count_o <= AE_LEVEL (0..DEPTH-1)
//  localparam PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
// PORTS
//  clk_i           in   1           clock, all state on rising edge
//  rst_i           in   1           asynchronous reset, active-high
//  flush_i         in   1           synchronous clear of all entries
//  in_valid_i      in   1           producer has data
//  in_ready_o      out  1           buffer can accept (= not full)
//  in_data_i       in   DATA_WIDTH  write data
//  out_valid_o     out  1           head entry available
//  out_ready_i     in   1           consumer takes head entry
//  out_data_o      out  DATA_WIDTH  head entry
//  count_o         out  CNT_W       occupancy, 0..DEPTH
//  almost_full_o   out  1           count_o >= AF_LEVEL
//  almost_empty_o  out  1           count_o <= AE_LEVEL
//  overflow_o      out  1           1-cycle pulse: write attempted while full
// BEHAVIOUR
//  - Reset (rst_i=1, async): wr_ptr=rd_ptr=0, count=0, all memory entries=0,
//    overflow_o=0. Outputs: in_ready_o=1, out_valid_o=0, out_data_o=0,
//    count_o=0, almost_full_o=(AF_LEVEL==0), almost_empty_o=1.
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - in_ready_o = (count != DEPTH); does NOT depend on out_ready_i, so a full
//    buffer never accepts even when popped in the same cycle.
//  - out_valid_o = (count != 0); out_data_o = mem[rd_ptr] (combinational read).
//  - Latency: entry pushed in cycle N is visible on out_* in cycle N+1.
//  - push writes mem[wr_ptr]; pointers advance by 1 and wrap DEPTH-1 -> 0
//    (explicit compare, no modulo-2^PTR_W wrap).
//  - count: push&~pop +1; pop&~push -1; both or neither unchanged. Never
//    exceeds DEPTH, never underflows.
//  - Push and pop in same cycle with count in 1..DEPTH-1: both occur, order
//    preserved, count unchanged.
//  - overflow_o registered: 1 in cycle after in_valid_i=1 & in_ready_o=0 and
//    flush_i=0; else 0. Rejected data is dropped, state unchanged.
//  - flush_i=1: next cycle pointers=0, count=0; push, pop and overflow in the
//    flush cycle are ignored (memory contents need not be cleared).
//  - rst_i asserted mid-transfer: all state returns to reset values
//    immediately; no partial write survives.
//  - almost_* derive combinationally from the count register only.
// CONFIGURATION
//  FIFO_OUT_BYPASS_EN defined: when count==0 and in_valid_i=1 (no flush),
//    out_valid_o=1 and out_data_o=in_data_i in the same cycle; if out_ready_i=1
//    the entry is consumed without being written (count stays 0, pointers
//    unchanged); if out_ready_i=0 it is written normally. Zero-cycle latency.
//  Not defined: no combinational in->out path; latency always 1 cycle.
// TESTING
//  1 Reset: rst_i=1 mid-traffic -> in_ready_o=1, out_valid_o=0, count_o=0,
//    out_data_o=0, almost_empty_o=1, overflow_o=0 in same cycle.
//  2 Fill DEPTH=4: push 0x1,0x2,0x3,0x4, out_ready_i=0 -> count_o 1..4,
//    almost_full_o=1 at count 3, in_ready_o=0 at 4; 5th push (0x5) ->
//    overflow_o=1 next cycle, 0x5 never appears at output.
//  3 Drain: out_ready_i=1 -> out_data_o 0x1,0x2,0x3,0x4 on consecutive
//    cycles, then out_valid_o=0, count_o=0.
//  4 Wrap: DEPTH=3, 10 entries streamed with simultaneous push/pop at count 1
//    -> output sequence equals input, count_o holds 1, pointers wrap at 2.
//  5 Flush: count_o=3, flush_i=1 with in_valid_i=1, out_ready_i=1 -> next
//    cycle count_o=0, out_valid_o=0, no entry popped or written.
//  6 Bypass (FIFO_OUT_BYPASS_EN): empty, in_valid_i=1 data 0xA5, out_ready_i=1
//    -> out_valid_o=1, out_data_o=0xA5 same cycle, count_o stays 0; without
//    macro -> out_valid_o=0 that cycle, 0xA5 at output next cycle.

Source files
------------

// File: rtl/fifo_out_buf.sv
// Output buffer between the divider datapath and the result consumer.
// First-word fall-through FIFO for any DEPTH >= 2, valid/ready on both sides.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync clear)
//   in_valid_i / in_ready_o / in_data_i    : producer side
//   out_valid_o / out_ready_i / out_data_o : consumer side (head entry)
//   count_o                                : occupancy 0..DEPTH
//   almost_full_o / almost_empty_o         : count_o >= AF_LEVEL / <= AE_LEVEL
//   overflow_o                             : pulse after a write was refused
//
// Optional macro FIFO_OUT_BYPASS_EN: zero-latency path from in_* to out_*
// while the buffer is empty.
module fifo_out_buf #(
  parameter int DATA_WIDTH = 65,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o
);

  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULLC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFC   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AEC   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  ovf;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic take;
  logic wr_en;
  logic rd_en;

  assign empty      = (count == '0);
  assign full       = (count == FULLC);
  assign in_ready_o = ~full;

`ifdef FIFO_OUT_BYPASS_EN
  logic bypass;

  // While empty the producer's word is presented directly; if the consumer
  // takes it in the same cycle it never touches the memory.
  assign bypass      = empty & in_valid_i & ~flush_i & ~rst_i;
  assign out_valid_o = ~empty | bypass;
  assign out_data_o  = bypass ? in_data_i : mem[rd_ptr];
  assign take        = bypass & out_ready_i;
`else
  assign out_valid_o = ~empty;
  assign out_data_o  = mem[rd_ptr];
  assign take        = 1'b0;
`endif

  assign push  = in_valid_i & in_ready_o & ~flush_i;
  assign pop   = out_valid_o & out_ready_i & ~flush_i;
  assign wr_en = push & ~take;
  assign rd_en = pop & ~take;

  assign count_o        = count;
  assign almost_full_o  = (count >= AFC);
  assign almost_empty_o = (count <= AEC);
  assign overflow_o     = ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= in_valid_i & ~in_ready_o;
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (wr_en & ~rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en & ~wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_out_buf.sv
// Bench for fifo_out_buf: DEPTH=4 and DEPTH=3 instances on shared inputs,
// directed scenarios plus random traffic against a queue model.
module tb_fifo_out_buf;

  localparam int DW = 65;
`ifdef FIFO_OUT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [DW-1:0] word_t;

  logic clk;
  logic rst;
  logic flush;
  logic in_valid;
  word_t in_data;
  logic out_ready;

  logic in_ready4, out_valid4, af4, ae4, ovf4;
  word_t out_data4;
  logic [2:0] count4;
  logic in_ready3, out_valid3, af3, ae3, ovf3;
  word_t out_data3;
  logic [1:0] count3;

  int nerr = 0;
  int nchk = 0;

  word_t q4[$];
  word_t q3[$];
  bit mov4;
  bit mov3;

  fifo_out_buf #(.DATA_WIDTH(DW), .DEPTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_data_i(in_data),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_data_o(out_data4),
    .count_o(count4), .almost_full_o(af4), .almost_empty_o(ae4),
    .overflow_o(ovf4)
  );

  fifo_out_buf #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready3), .in_data_i(in_data),
    .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_data_o(out_data3),
    .count_o(count3), .almost_full_o(af3), .almost_empty_o(ae3),
    .overflow_o(ovf3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; the queue model applies the buffer rules at the edge.
  task automatic tick();
    word_t q[$];
    bit ov, full, byp, pop, push;
    int d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin q = q4; ov = mov4; d = 4; end
      else begin q = q3; ov = mov3; d = 3; end
      if (rst || flush) begin
        q.delete();
        ov = 1'b0;
      end else begin
        full = (q.size() == d);
        ov   = in_valid && full;
        byp  = BYP && (q.size() == 0) && in_valid;
        pop  = out_ready && ((q.size() != 0) || byp);
        push = in_valid && !full;
        if (!(byp && pop)) begin
          if (pop) void'(q.pop_front());
          if (push) q.push_back(in_data);
        end
      end
      if (k == 0) begin q4 = q; mov4 = ov; end
      else begin q3 = q; mov3 = ov; end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = DW'(i); out_ready = 0;
      tick();
    end
    nchk++; if (ovf4 !== 1'b1) begin nerr++; $display("FAIL rst_pre_ovf: got %b expected 1", ovf4); end
    in_data = DW'(64'hDEAD_BEEF_0123_4567);
    #2 rst = 1;
    #1;
    nchk++; if (in_ready4 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b expected 1", in_ready4); end
    nchk++; if (out_valid4 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b expected 0", out_valid4); end
    nchk++; if (count4 !== 3'd0) begin nerr++; $display("FAIL rst_count: got %0d expected 0", count4); end
    nchk++; if (out_data4 !== '0) begin nerr++; $display("FAIL rst_out_data: got %h expected 0", out_data4); end
    nchk++; if (ae4 !== 1'b1) begin nerr++; $display("FAIL rst_almost_empty: got %b expected 1", ae4); end
    nchk++; if (af4 !== 1'b0) begin nerr++; $display("FAIL rst_almost_full: got %b expected 0", af4); end
    nchk++; if (ovf4 !== 1'b0) begin nerr++; $display("FAIL rst_overflow: got %b expected 0", ovf4); end
    nchk++; if (count3 !== 2'd0) begin nerr++; $display("FAIL rst_count3: got %0d expected 0", count3); end
    @(negedge clk);
    tick();
    rst = 0;
    idle();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = DW'(i); out_ready = 0;
      tick();
      nchk++; if (count4 !== 3'(i)) begin nerr++; $display("FAIL fill_count: got %0d expected %0d", count4, i); end
      nchk++; if (af4 !== (i >= 3)) begin nerr++; $display("FAIL fill_af: got %b expected %b at %0d", af4, (i >= 3), i); end
      nchk++; if (in_ready4 !== (i < 4)) begin nerr++; $display("FAIL fill_ready: got %b expected %b at %0d", in_ready4, (i < 4), i); end
    end
    in_data = DW'(5);
    tick();
    nchk++; if (ovf4 !== 1'b1) begin nerr++; $display("FAIL fill_ovf: got %b expected 1", ovf4); end
    nchk++; if (count4 !== 3'd4) begin nerr++; $display("FAIL fill_ovf_count: got %0d expected 4", count4); end
    in_valid = 0;
    tick();
    nchk++; if (ovf4 !== 1'b0) begin nerr++; $display("FAIL fill_ovf_clear: got %b expected 0", ovf4); end
  endtask

  task automatic test_drain();
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      nchk++; if (out_valid4 !== 1'b1) begin nerr++; $display("FAIL drain_valid: got %b expected 1", out_valid4); end
      nchk++; if (out_data4 !== DW'(i)) begin nerr++; $display("FAIL drain_data: got %h expected %h", out_data4, DW'(i)); end
      tick();
    end
    nchk++; if (out_valid4 !== 1'b0) begin nerr++; $display("FAIL drain_empty: got %b expected 0", out_valid4); end
    nchk++; if (count4 !== 3'd0) begin nerr++; $display("FAIL drain_count: got %0d expected 0", count4); end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1; in_data = DW'(100); out_ready = 0;
    tick();
    for (int i = 1; i <= 9; i++) begin
      in_data = DW'(100 + i); out_ready = 1;
      #1;
      nchk++; if (out_data3 !== DW'(100 + i - 1)) begin nerr++; $display("FAIL wrap_data: got %h expected %h", out_data3, DW'(100 + i - 1)); end
      tick();
      nchk++; if (count3 !== 2'd1) begin nerr++; $display("FAIL wrap_count: got %0d expected 1", count3); end
    end
    in_valid = 0;
    #1;
    nchk++; if (out_data3 !== DW'(109)) begin nerr++; $display("FAIL wrap_last: got %h expected %h", out_data3, DW'(109)); end
    tick();
    nchk++; if (count3 !== 2'd0) begin nerr++; $display("FAIL wrap_end_count: got %0d expected 0", count3); end
    out_ready = 0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = DW'(32 + i); out_ready = 0;
      tick();
    end
    nchk++; if (count4 !== 3'd3) begin nerr++; $display("FAIL flush_pre_count: got %0d expected 3", count4); end
    flush = 1; in_valid = 1; in_data = DW'(8'h77); out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    nchk++; if (count4 !== 3'd0) begin nerr++; $display("FAIL flush_count: got %0d expected 0", count4); end
    nchk++; if (out_valid4 !== 1'b0) begin nerr++; $display("FAIL flush_valid: got %b expected 0", out_valid4); end
    nchk++; if (ovf4 !== 1'b0) begin nerr++; $display("FAIL flush_ovf: got %b expected 0", ovf4); end
    in_valid = 1; in_data = DW'(8'h88);
    tick();
    in_valid = 0;
    #1;
    nchk++; if (out_data4 !== DW'(8'h88)) begin nerr++; $display("FAIL flush_after_data: got %h expected 88", out_data4); end
    nchk++; if (count4 !== 3'd1) begin nerr++; $display("FAIL flush_after_count: got %0d expected 1", count4); end
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1; in_data = DW'(8'hA5); out_ready = 1;
    #1;
    nchk++; if (out_valid4 !== BYP) begin nerr++; $display("FAIL byp_valid: got %b expected %b", out_valid4, BYP); end
    if (BYP) begin
      nchk++; if (out_data4 !== DW'(8'hA5)) begin nerr++; $display("FAIL byp_data: got %h expected a5", out_data4); end
    end
    tick();
    in_valid = 0; out_ready = 0;
    #1;
    nchk++; if (count4 !== (BYP ? 3'd0 : 3'd1)) begin nerr++; $display("FAIL byp_count: got %0d expected %0d", count4, BYP ? 0 : 1); end
    nchk++; if (out_valid4 !== !BYP) begin nerr++; $display("FAIL byp_next_valid: got %b expected %b", out_valid4, !BYP); end
    if (!BYP) begin
      nchk++; if (out_data4 !== DW'(8'hA5)) begin nerr++; $display("FAIL byp_next_data: got %h expected a5", out_data4); end
    end
  endtask

  task automatic test_random();
    bit ev;
    word_t ed;
    int ph;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ph = (c / 50) % 2;
      in_valid  = ($urandom_range(99) < (ph != 0 ? 85 : 35));
      out_ready = ($urandom_range(99) < (ph != 0 ? 35 : 85));
      flush     = ($urandom_range(99) < 3);
      in_data   = DW'({$urandom(), $urandom(), $urandom()});
      #1;
      ev = (q4.size() != 0) || (BYP && in_valid && !flush);
      ed = (q4.size() != 0) ? q4[0] : in_data;
      nchk++; if (out_valid4 !== ev) begin nerr++; $display("FAIL rnd4_valid c=%0d: got %b expected %b", c, out_valid4, ev); end
      if (ev) begin
        nchk++; if (out_data4 !== ed) begin nerr++; $display("FAIL rnd4_data c=%0d: got %h expected %h", c, out_data4, ed); end
      end
      nchk++; if (count4 !== 3'(q4.size())) begin nerr++; $display("FAIL rnd4_count c=%0d: got %0d expected %0d", c, count4, q4.size()); end
      nchk++; if (in_ready4 !== (q4.size() != 4)) begin nerr++; $display("FAIL rnd4_ready c=%0d: got %b", c, in_ready4); end
      nchk++; if (af4 !== (q4.size() >= 3)) begin nerr++; $display("FAIL rnd4_af c=%0d: got %b", c, af4); end
      nchk++; if (ae4 !== (q4.size() <= 1)) begin nerr++; $display("FAIL rnd4_ae c=%0d: got %b", c, ae4); end
      nchk++; if (ovf4 !== mov4) begin nerr++; $display("FAIL rnd4_ovf c=%0d: got %b expected %b", c, ovf4, mov4); end
      ev = (q3.size() != 0) || (BYP && in_valid && !flush);
      ed = (q3.size() != 0) ? q3[0] : in_data;
      nchk++; if (out_valid3 !== ev) begin nerr++; $display("FAIL rnd3_valid c=%0d: got %b expected %b", c, out_valid3, ev); end
      if (ev) begin
        nchk++; if (out_data3 !== ed) begin nerr++; $display("FAIL rnd3_data c=%0d: got %h expected %h", c, out_data3, ed); end
      end
      nchk++; if (count3 !== 2'(q3.size())) begin nerr++; $display("FAIL rnd3_count c=%0d: got %0d expected %0d", c, count3, q3.size()); end
      nchk++; if (in_ready3 !== (q3.size() != 3)) begin nerr++; $display("FAIL rnd3_ready c=%0d: got %b", c, in_ready3); end
      nchk++; if (af3 !== (q3.size() >= 3)) begin nerr++; $display("FAIL rnd3_af c=%0d: got %b", c, af3); end
      nchk++; if (ae3 !== (q3.size() <= 1)) begin nerr++; $display("FAIL rnd3_ae c=%0d: got %b", c, ae3); end
      nchk++; if (ovf3 !== mov3) begin nerr++; $display("FAIL rnd3_ovf c=%0d: got %b expected %b", c, ovf3, mov3); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    tick();
    rst = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
